// File: rtl/condicionador_botoes.sv
// Button conditioner: synchronises four raw push-buttons, debounces press and
// release, rejects multi-button chords and emits one clean code per press.
module condicionador_botoes #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] botoes_in,
   output logic [3:0] botoes,
   output logic       jogada_pulso,
   output logic       erro_multiplo,
   output logic [3:0] db_estado
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [3:0] {
      OCIOSO      = 4'd0,
      FILTRA      = 4'd1,
      PRESSIONADO = 4'd2,
      SOLTANDO    = 4'd3,
      INVALIDO    = 4'd4
   } estado_t;

   logic [3:0]    r_sync1;
   logic [3:0]    r_b_s;
   logic [3:0]    r_cand;
   logic [CW-1:0] r_cnt;
   estado_t       r_estado;
   logic [3:0]    r_botoes;
   logic          r_jogada;
   logic          r_erro;

   estado_t       w_estado_next;
   logic [3:0]    w_cand_next;
   logic [CW-1:0] w_cnt_next;
   logic [3:0]    w_botoes_next;
   logic          w_jogada_next;
   logic          w_erro_next;
   logic          w_one_hot;

   assign w_one_hot = (r_cand != 4'd0) && ((r_cand & (r_cand - 4'd1)) == 4'd0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sync1  <= 4'd0;
         r_b_s    <= 4'd0;
         r_cand   <= 4'd0;
         r_cnt    <= '0;
         r_estado <= OCIOSO;
         r_botoes <= 4'd0;
         r_jogada <= 1'b0;
         r_erro   <= 1'b0;
      end else begin
         r_sync1  <= botoes_in;
         r_b_s    <= r_sync1;
         r_cand   <= w_cand_next;
         r_cnt    <= w_cnt_next;
         r_estado <= w_estado_next;
         r_botoes <= w_botoes_next;
         r_jogada <= w_jogada_next;
         r_erro   <= w_erro_next;
      end
   end

   always_comb begin
      w_estado_next = r_estado;
      w_cand_next   = r_cand;
      w_cnt_next    = r_cnt;
      w_botoes_next = r_botoes;
      w_jogada_next = 1'b0;
      w_erro_next   = 1'b0;
      case (r_estado)
         OCIOSO: begin
            w_botoes_next = 4'd0;
            if (r_b_s != 4'd0) begin
               w_cand_next   = r_b_s;
               w_cnt_next    = CNT_ONE;
               w_estado_next = FILTRA;
            end
         end
         FILTRA: begin
            if (r_b_s == 4'd0) begin
               w_estado_next = OCIOSO;
            end else if (r_b_s != r_cand) begin
               // Pattern changed mid-filter: restart the count on the new pattern.
               w_cand_next = r_b_s;
               w_cnt_next  = CNT_ONE;
            end else if (r_cnt == CNT_MAX) begin
               if (w_one_hot) begin
                  w_botoes_next = r_cand;
                  w_jogada_next = 1'b1;
                  w_estado_next = PRESSIONADO;
               end else begin
                  w_erro_next   = 1'b1;
                  w_estado_next = INVALIDO;
               end
            end else begin
               w_cnt_next = r_cnt + CNT_ONE;
            end
         end
         PRESSIONADO: begin
            // Any change, including an added button, starts the release filter.
            if (r_b_s != r_cand) begin
               w_estado_next = SOLTANDO;
               w_cnt_next    = (r_b_s == 4'd0) ? CNT_ONE : '0;
            end
         end
         SOLTANDO, INVALIDO: begin
            if (r_estado == INVALIDO) w_botoes_next = 4'd0;
            if (r_b_s != 4'd0) begin
               w_cnt_next = '0;
            end else if (r_cnt == CNT_MAX) begin
               w_botoes_next = 4'd0;
               w_estado_next = OCIOSO;
            end else begin
               w_cnt_next = r_cnt + CNT_ONE;
            end
         end
         default: begin
            w_estado_next = OCIOSO;
            w_botoes_next = 4'd0;
            w_cnt_next    = '0;
         end
      endcase
   end

   assign botoes        = r_botoes;
   assign jogada_pulso  = r_jogada;
   assign erro_multiplo = r_erro;
   assign db_estado     = r_estado;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Directed bench for condicionador_botoes with DEBOUNCE_CYCLES = 4:
// press/release latency, bounce, chord, added button, async reset, release glitch.
module tb_condicionador_botoes;

   logic       clock;
   logic       reset;
   logic [3:0] botoes_in;
   logic [3:0] botoes;
   logic       jogada_pulso;
   logic       erro_multiplo;
   logic [3:0] db_estado;

   int total;
   int bad;

   condicionador_botoes #(.DEBOUNCE_CYCLES(4)) dut (
      .clock         (clock),
      .reset         (reset),
      .botoes_in     (botoes_in),
      .botoes        (botoes),
      .jogada_pulso  (jogada_pulso),
      .erro_multiplo (erro_multiplo),
      .db_estado     (db_estado)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      botoes_in = 4'd0;
      tick();
      tick();
      total++; if (botoes !== 4'd0) begin bad++; $display("FAIL reset_botoes got=%b want=0000", botoes); end
      total++; if (jogada_pulso !== 1'b0) begin bad++; $display("FAIL reset_pulso got=%b want=0", jogada_pulso); end
      total++; if (erro_multiplo !== 1'b0) begin bad++; $display("FAIL reset_erro got=%b want=0", erro_multiplo); end
      total++; if (db_estado !== 4'd0) begin bad++; $display("FAIL reset_estado got=%0d want=0", db_estado); end
      reset = 1'b0;
      repeat (3) tick();
      total++; if (db_estado !== 4'd0) begin bad++; $display("FAIL idle_estado got=%0d want=0", db_estado); end
   endtask

   task automatic test_clean_press();
      logic [3:0] exp_p[6];
      logic [3:0] exp_r[6];
      exp_p = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
      exp_r = '{4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd0};
      botoes_in = 4'b0100;
      for (int i = 0; i < 6; i++) begin
         tick();
         total++; if (db_estado !== exp_p[i]) begin bad++; $display("FAIL clean_press_estado t=%0d got=%0d want=%0d", i+1, db_estado, exp_p[i]); end
         total++; if (jogada_pulso !== (i == 5)) begin bad++; $display("FAIL clean_press_pulso t=%0d got=%b want=%b", i+1, jogada_pulso, (i == 5)); end
         total++; if (botoes !== ((i == 5) ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL clean_press_botoes t=%0d got=%b", i+1, botoes); end
      end
      repeat (3) begin
         tick();
         total++; if (jogada_pulso !== 1'b0 || botoes !== 4'b0100) begin bad++; $display("FAIL clean_hold got pulso=%b botoes=%b want 0/0100", jogada_pulso, botoes); end
      end
      botoes_in = 4'b0000;
      for (int i = 0; i < 6; i++) begin
         tick();
         total++; if (db_estado !== exp_r[i]) begin bad++; $display("FAIL clean_release_estado t=%0d got=%0d want=%0d", i+1, db_estado, exp_r[i]); end
         total++; if (botoes !== ((i == 5) ? 4'b0000 : 4'b0100)) begin bad++; $display("FAIL clean_release_botoes t=%0d got=%b", i+1, botoes); end
         total++; if (jogada_pulso !== 1'b0) begin bad++; $display("FAIL clean_release_pulso t=%0d got=%b want=0", i+1, jogada_pulso); end
      end
      repeat (3) tick();
   endtask

   task automatic test_bounce();
      int pulses;
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         botoes_in = 4'b0001; tick(); if (jogada_pulso) pulses++;
         tick(); if (jogada_pulso) pulses++;
         botoes_in = 4'b0000; tick(); if (jogada_pulso) pulses++;
      end
      botoes_in = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         tick(); if (jogada_pulso) pulses++;
      end
      total++; if (pulses !== 0) begin bad++; $display("FAIL bounce_early_pulses got=%0d want=0", pulses); end
      tick();
      total++; if (jogada_pulso !== 1'b1 || botoes !== 4'b0001) begin bad++; $display("FAIL bounce_accept got pulso=%b botoes=%b want 1/0001", jogada_pulso, botoes); end
      pulses = 0;
      botoes_in = 4'b0000;
      for (int i = 0; i < 8; i++) begin
         tick(); if (jogada_pulso) pulses++;
      end
      total++; if (pulses !== 0 || botoes !== 4'd0 || db_estado !== 4'd0) begin bad++; $display("FAIL bounce_release got pulses=%0d botoes=%b estado=%0d want 0/0000/0", pulses, botoes, db_estado); end
   endtask

   task automatic test_chord();
      int pulses;
      pulses = 0;
      botoes_in = 4'b0011;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (jogada_pulso) pulses++;
         total++; if (erro_multiplo !== (i == 5)) begin bad++; $display("FAIL chord_erro t=%0d got=%b want=%b", i+1, erro_multiplo, (i == 5)); end
         total++; if (botoes !== 4'd0) begin bad++; $display("FAIL chord_botoes t=%0d got=%b want=0000", i+1, botoes); end
      end
      total++; if (db_estado !== 4'd4) begin bad++; $display("FAIL chord_estado got=%0d want=4", db_estado); end
      repeat (3) begin
         tick();
         if (jogada_pulso) pulses++;
         total++; if (erro_multiplo !== 1'b0 || db_estado !== 4'd4) begin bad++; $display("FAIL chord_hold got erro=%b estado=%0d want 0/4", erro_multiplo, db_estado); end
      end
      botoes_in = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         tick(); if (jogada_pulso) pulses++;
      end
      total++; if (db_estado !== 4'd4) begin bad++; $display("FAIL chord_release_early got=%0d want=4", db_estado); end
      tick(); if (jogada_pulso) pulses++;
      total++; if (db_estado !== 4'd0) begin bad++; $display("FAIL chord_release_estado got=%0d want=0", db_estado); end
      total++; if (pulses !== 0) begin bad++; $display("FAIL chord_pulses got=%0d want=0", pulses); end
      repeat (2) tick();
   endtask

   task automatic test_add_button();
      int pulses;
      botoes_in = 4'b1000;
      repeat (6) tick();
      total++; if (jogada_pulso !== 1'b1 || botoes !== 4'b1000) begin bad++; $display("FAIL add_accept got pulso=%b botoes=%b want 1/1000", jogada_pulso, botoes); end
      pulses = 0;
      botoes_in = 4'b1001;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (jogada_pulso) pulses++;
         total++; if (botoes !== 4'b1000) begin bad++; $display("FAIL add_hold_botoes t=%0d got=%b want=1000", i+1, botoes); end
      end
      total++; if (db_estado !== 4'd3) begin bad++; $display("FAIL add_estado got=%0d want=3", db_estado); end
      botoes_in = 4'b0000;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (jogada_pulso) pulses++;
         total++; if (botoes !== ((i == 5) ? 4'b0000 : 4'b1000)) begin bad++; $display("FAIL add_release_botoes t=%0d got=%b", i+1, botoes); end
      end
      total++; if (pulses !== 0) begin bad++; $display("FAIL add_pulses got=%0d want=0", pulses); end
      repeat (2) tick();
      botoes_in = 4'b0010;
      repeat (5) tick();
      total++; if (jogada_pulso !== 1'b0) begin bad++; $display("FAIL next_press_early got=%b want=0", jogada_pulso); end
      tick();
      total++; if (jogada_pulso !== 1'b1 || botoes !== 4'b0010) begin bad++; $display("FAIL next_press got pulso=%b botoes=%b want 1/0010", jogada_pulso, botoes); end
      botoes_in = 4'b0000;
      repeat (8) tick();
   endtask

   task automatic test_reset_mid();
      botoes_in = 4'b0010;
      repeat (8) tick();
      total++; if (botoes !== 4'b0010) begin bad++; $display("FAIL rmid_pre got=%b want=0010", botoes); end
      #2 reset = 1'b1;
      #1;
      total++; if (botoes !== 4'd0 || db_estado !== 4'd0 || jogada_pulso !== 1'b0) begin bad++; $display("FAIL rmid_async got botoes=%b estado=%0d pulso=%b want 0000/0/0", botoes, db_estado, jogada_pulso); end
      tick();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         total++; if (jogada_pulso !== (i == 5)) begin bad++; $display("FAIL rmid_pulso t=%0d got=%b want=%b", i+1, jogada_pulso, (i == 5)); end
      end
      total++; if (botoes !== 4'b0010) begin bad++; $display("FAIL rmid_botoes got=%b want=0010", botoes); end
      botoes_in = 4'b0000;
      repeat (8) tick();
   endtask

   task automatic test_release_glitch();
      int pulses;
      botoes_in = 4'b0100;
      repeat (6) tick();
      total++; if (jogada_pulso !== 1'b1) begin bad++; $display("FAIL glitch_accept got=%b want=1", jogada_pulso); end
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         botoes_in = 4'b0000;
         repeat (2) begin
            tick(); if (jogada_pulso) pulses++;
            total++; if (botoes !== 4'b0100) begin bad++; $display("FAIL glitch_hold_low k=%0d got=%b want=0100", k, botoes); end
         end
         botoes_in = 4'b0100;
         repeat (2) begin
            tick(); if (jogada_pulso) pulses++;
            total++; if (botoes !== 4'b0100) begin bad++; $display("FAIL glitch_hold_high k=%0d got=%b want=0100", k, botoes); end
         end
      end
      repeat (2) begin tick(); if (jogada_pulso) pulses++; end
      botoes_in = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         tick(); if (jogada_pulso) pulses++;
      end
      total++; if (botoes !== 4'b0100) begin bad++; $display("FAIL glitch_release_early got=%b want=0100", botoes); end
      tick();
      total++; if (botoes !== 4'b0000 || db_estado !== 4'd0) begin bad++; $display("FAIL glitch_release got botoes=%b estado=%0d want 0000/0", botoes, db_estado); end
      total++; if (pulses !== 0) begin bad++; $display("FAIL glitch_pulses got=%0d want=0", pulses); end
   endtask

   initial begin
      total = 0;
      bad = 0;
      reset = 1'b1;
      botoes_in = 4'd0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_chord();
      test_add_button();
      test_reset_mid();
      test_release_glitch();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/condicionador_botoes.md
# condicionador_botoes

Input-conditioning stage that sits directly upstream of `circuito_jogo_base` and drives its `botoes` input. It synchronises the four raw push-buttons, debounces presses and releases, and rejects multi-button chords. It delivers one clean one-hot code, plus a single-cycle `jogada_pulso`, per physical press. No new press is accepted until all buttons have been stably released.

## Interface
- `DEBOUNCE_CYCLES`, default 50000, consecutive synchronised samples needed to accept a press or a release; legal minimum 2. Counter width is `$clog2(DEBOUNCE_CYCLES)`.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears every register, including the synchroniser.
- `botoes_in`  in  4  raw, asynchronous, bouncing button levels; 1 = pressed.
- `botoes`  out  4  conditioned code to the game core. Holds the accepted one-hot value from acceptance until the release is debounced; otherwise 4'b0000.
- `jogada_pulso`  out  1  one-cycle pulse on acceptance of a valid one-hot press.
- `erro_multiplo`  out  1  one-cycle pulse on acceptance of a stable pattern with more than one bit set.
- `db_estado`  out  4  current state encoding, for hexa7seg debug.

## Operation
- Synchroniser: two-flop chain per bit, giving `b_s`. The FSM uses only `b_s`.
- Registers: `cand` (4 bits), counter `cnt`, state, `botoes`, and the two pulse flops. All outputs are registered.
- States (value of `db_estado`):
  - OCIOSO = 0
  - FILTRA = 1
  - PRESSIONADO = 2
  - SOLTANDO = 3
  - INVALIDO = 4
- OCIOSO: `botoes` = 0. If `b_s` != 0, then `cand` <= `b_s`, `cnt` <= 1, go to FILTRA. Otherwise stay.
- FILTRA, decided in this order:
  - `b_s` == 0: go to OCIOSO (glitch).
  - `b_s` != `cand`: `cand` <= `b_s`, `cnt` <= 1, stay (pattern changed, so the count restarts).
  - `b_s` == `cand` and `cnt` == DEBOUNCE_CYCLES-1: accept.
    - `cand` is one-hot: `botoes` <= `cand`, `jogada_pulso` <= 1, go to PRESSIONADO.
    - Otherwise: `erro_multiplo` <= 1, go to INVALIDO.
  - Otherwise: `cnt`++.
- PRESSIONADO: `botoes` is held. If `b_s` != `cand`, go to SOLTANDO with `cnt` <= (`b_s` == 0 ? 1 : 0). Adding a second button also counts as leaving.
- SOLTANDO and INVALIDO: release filter.
  - `b_s` != 0: `cnt` <= 0.
  - `b_s` == 0 and `cnt` == DEBOUNCE_CYCLES-1: `botoes` <= 0, go to OCIOSO.
  - `b_s` == 0 otherwise: `cnt`++.
- In SOLTANDO, `botoes` keeps the accepted code. In INVALIDO, `botoes` = 0.
- Illegal state encodings return to OCIOSO on the next edge.

## Timing
- Reset values: `botoes` = 0, `jogada_pulso` = 0, `erro_multiplo` = 0, `db_estado` = 0. `cnt`, `cand` and the synchroniser are also 0.
- Press latency: raw input clean and stable before edge e0.
  - `b_s` is first sampled by the FSM at e2.
  - Acceptance happens at edge e(DEBOUNCE_CYCLES+1).
  - `jogada_pulso` and the new `botoes` are visible in the cycle after that edge, i.e. DEBOUNCE_CYCLES+2 edges after the raw press.
- Release latency: clean release before edge r0 clears `botoes` DEBOUNCE_CYCLES+2 edges later.
- Pulses are exactly one cycle wide. At most one `jogada_pulso` or `erro_multiplo` per press/release cycle.
- `botoes` is nonzero whenever `jogada_pulso` is high. The consumer may sample both in the same cycle.
- A bounce shorter than DEBOUNCE_CYCLES samples never produces a pulse.
- Reset asserted mid-press clears all outputs immediately (asynchronous).
  - After deassertion, a button still held is treated as a new press.
  - It pulses after the full press latency.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.

1. Reset, then hold `botoes_in` = 4'b0100 clean.
   - `jogada_pulso` is high for exactly 1 cycle, 6 edges after the press.
   - `botoes` = 4'b0100 until 6 edges after release, then 0.
   - `db_estado` follows 0 → 1 → 2 → 3 → 0.
2. Bounce 4'b0001 on for 2 cycles / off for 1, repeated 3 times, then hold.
   - Exactly one `jogada_pulso`, 6 edges after the final stable start.
3. Press 4'b0011 and hold.
   - `erro_multiplo` pulses once; `botoes` stays 0; `db_estado` = 4.
   - After release ≥ 6 cycles, `db_estado` = 0 and there is no `jogada_pulso`.
4. Accept 4'b1000, then add bit 0 (4'b1001) while held.
   - No second pulse; `botoes` stays 4'b1000 until full stable release.
   - A following 4'b0010 press pulses normally.
5. Assert `reset` for 1 cycle while `botoes` = 4'b0010 and the button is still held.
   - Outputs go to 0 asynchronously.
   - `jogada_pulso` fires again 6 edges after `reset` deasserts.
6. Release glitch: in PRESSIONADO, drop to 0 for 2 cycles, then press again, repeated.
   - `botoes` holds its value and there is no new pulse until a 4-sample stable release occurs.
